// File: rtl/vctrl_pkg.sv
// Shared constants and types for the vector hazard controller:
// register-file geometry, default multiply latency and forwarding selects.
package vctrl_pkg;

    localparam int NUM_VREGS = 32;
    localparam int VREG_W    = 5;
    localparam int MUL_LAT   = 4;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // EX/MEM is the younger producer, so it wins over MEM/WB when both match.
    function automatic fwd_sel_e fwdSelect(
        input logic              idexValid,
        input logic [VREG_W-1:0] src,
        input logic              exmemValid,
        input logic              exmemVwe,
        input logic [VREG_W-1:0] exmemVrd,
        input logic              memwbValid,
        input logic              memwbVwe,
        input logic [VREG_W-1:0] memwbVrd
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (idexValid) begin
            if (exmemValid && exmemVwe && (exmemVrd == src)) begin
                sel = FWD_EXMEM;
            end else if (memwbValid && memwbVwe && (memwbVrd == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/vhazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: ID, ID/EX, EX/MEM and
// MEM/WB status going in, stall/forward/multiply control coming out.
interface vhazard_ctrl_if;
    import vctrl_pkg::*;

    logic              id_valid;
    logic [VREG_W-1:0] id_vrs1;
    logic [VREG_W-1:0] id_vrs2;
    logic [VREG_W-1:0] id_vrd;
    logic              id_vwe;
    logic              id_vmul;

    logic              idex_valid;
    logic              idex_vwe;
    logic              idex_vload;
    logic [VREG_W-1:0] idex_vrs1;
    logic [VREG_W-1:0] idex_vrs2;
    logic [VREG_W-1:0] idex_vrd;

    logic              exmem_valid;
    logic              exmem_vwe;
    logic [VREG_W-1:0] exmem_vrd;

    logic              memwb_valid;
    logic              memwb_vwe;
    logic [VREG_W-1:0] memwb_vrd;

    logic              stall;
    logic [1:0]        fwdA_sel;
    logic [1:0]        fwdB_sel;
    logic              vmul_start;
    logic              vmul_busy;
    logic              vmul_done;

    modport master (
        output id_valid, id_vrs1, id_vrs2, id_vrd, id_vwe, id_vmul,
        output idex_valid, idex_vwe, idex_vload, idex_vrs1, idex_vrs2, idex_vrd,
        output exmem_valid, exmem_vwe, exmem_vrd,
        output memwb_valid, memwb_vwe, memwb_vrd,
        input  stall, fwdA_sel, fwdB_sel, vmul_start, vmul_busy, vmul_done
    );

    modport slave (
        input  id_valid, id_vrs1, id_vrs2, id_vrd, id_vwe, id_vmul,
        input  idex_valid, idex_vwe, idex_vload, idex_vrs1, idex_vrs2, idex_vrd,
        input  exmem_valid, exmem_vwe, exmem_vrd,
        input  memwb_valid, memwb_vwe, memwb_vrd,
        output stall, fwdA_sel, fwdB_sel, vmul_start, vmul_busy, vmul_done
    );

endinterface

// File: rtl/vhazard_ctrl_vmul_sequencer.sv
// Tracks the single outstanding vector multiply: latency down-counter,
// latched destination register and the one-cycle done strobe.
module vmul_sequencer #(
    parameter int MUL_LAT = vctrl_pkg::MUL_LAT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic [vctrl_pkg::VREG_W-1:0]  vrd_i,
    output logic [vctrl_pkg::CNT_W-1:0]   count_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [vctrl_pkg::VREG_W-1:0]  vrd_o
);
    import vctrl_pkg::*;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [VREG_W-1:0] vrd_q, vrd_d;

    // A new launch reloads the counter even in the done cycle, which is
    // what lets multiplies issue back to back.
    always_comb begin
        count_d = count_q;
        vrd_d   = vrd_q;
        if (start_i) begin
            count_d = CNT_W'(MUL_LAT);
            vrd_d   = vrd_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Reset abandons any multiply in flight so no done pulse follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            vrd_q   <= '0;
        end else begin
            count_q <= count_d;
            vrd_q   <= vrd_d;
        end
    end

    assign count_o = count_q;
    assign busy_o  = (count_q != '0);
    assign done_o  = (count_q == CNT_W'(1));
    assign vrd_o   = vrd_q;

endmodule

// File: rtl/vhazard_ctrl.sv
// Vector pipeline hazard controller: operand forwarding selects, load-use
// stall, pending-write scoreboard for the multi-cycle multiply and the
// structural stall while the single multiplier is occupied.
module vhazard_ctrl #(
    parameter int NUM_VREGS = vctrl_pkg::NUM_VREGS,
    parameter int MUL_LAT   = vctrl_pkg::MUL_LAT
) (
    input  logic           clk,
    input  logic           reset,
    vhazard_ctrl_if.slave  bus
);
    import vctrl_pkg::*;

    logic [CNT_W-1:0]     seqCount;
    logic                 seqBusy;
    logic                 seqDone;
    logic [VREG_W-1:0]    seqVrd;

    logic [NUM_VREGS-1:0] pending_q, pending_d;

    logic loadUseStall;
    logic rawStall;
    logic wawStall;
    logic structStall;
    logic stallAll;
    logic vmulStart;

    vmul_sequencer #(
        .MUL_LAT (MUL_LAT)
    ) u_seq (
        .clk     (clk),
        .reset   (reset),
        .start_i (vmulStart),
        .vrd_i   (bus.id_vrd),
        .count_o (seqCount),
        .busy_o  (seqBusy),
        .done_o  (seqDone),
        .vrd_o   (seqVrd)
    );

    // Stall causes; a WAW against the register being written back in this
    // very cycle is harmless because the new write lands later, so that case
    // is excused to let a same-destination multiply issue back to back.
    always_comb begin
        loadUseStall = bus.id_valid & bus.idex_valid & bus.idex_vload & bus.idex_vwe &
                       ((bus.idex_vrd == bus.id_vrs1) | (bus.idex_vrd == bus.id_vrs2));
        rawStall     = bus.id_valid & (pending_q[bus.id_vrs1] | pending_q[bus.id_vrs2]);
        wawStall     = bus.id_valid & bus.id_vwe & pending_q[bus.id_vrd] &
                       ~(seqDone & (seqVrd == bus.id_vrd));
        structStall  = bus.id_valid & bus.id_vmul & (seqCount > CNT_W'(1));
        stallAll     = loadUseStall | rawStall | wawStall | structStall;
        vmulStart    = bus.id_valid & bus.id_vmul & ~stallAll;
    end

    // Scoreboard update: the completing destination clears first so a
    // launch to the same register in the done cycle keeps its bit set.
    always_comb begin
        pending_d = pending_q;
        if (seqDone) begin
            pending_d[seqVrd] = 1'b0;
        end
        if (vmulStart) begin
            pending_d[bus.id_vrd] = 1'b1;
        end
    end

    // Scoreboard register, wiped on reset together with the sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.stall      = stallAll;
    assign bus.vmul_start = vmulStart;
    assign bus.vmul_busy  = seqBusy;
    assign bus.vmul_done  = seqDone;
    assign bus.fwdA_sel   = fwdSelect(bus.idex_valid, bus.idex_vrs1,
                                      bus.exmem_valid, bus.exmem_vwe, bus.exmem_vrd,
                                      bus.memwb_valid, bus.memwb_vwe, bus.memwb_vrd);
    assign bus.fwdB_sel   = fwdSelect(bus.idex_valid, bus.idex_vrs2,
                                      bus.exmem_valid, bus.exmem_vwe, bus.exmem_vrd,
                                      bus.memwb_valid, bus.memwb_vwe, bus.memwb_vrd);

endmodule
